// File: rtl/lvt_multiport_ram_if.sv
// Bus bundle for lvt_multiport_ram: flattened write ports, read ports and ready.
// The master drives writes and read addresses; the slave returns read data and ready.
interface lvt_multiport_ram_if #(
   parameter int AW = 11,
   parameter int DW = 32,
   parameter int NW = 2,
   parameter int NR = 2
);
   logic [NW-1:0]    w_en;
   logic [NW*AW-1:0] w_addr;
   logic [NW*DW-1:0] w_din;
   logic [NR*AW-1:0] r_addr;
   logic [NR*DW-1:0] r_dout;
   logic             ready;

   modport master (output w_en, w_addr, w_din, r_addr, input r_dout, ready);
   modport slave  (input w_en, w_addr, w_din, r_addr, output r_dout, ready);
endinterface

// File: rtl/lvt_multiport_ram.sv
// NW-write / NR-read RAM built from per-(write,read) replicated banks plus a live value table
// that steers each read port to the bank of the last writer, with a post-reset clear sweep.
//
// state | meaning
// INIT  | clearing every bank and LVT entry at ptr, one address per cycle; writes ignored
// READY | normal operation; terminal until reset
module lvt_multiport_ram #(
   parameter int BLOCKSIZE = 10,
   parameter int DW        = 32,
   parameter int NW        = 2,
   parameter int NR        = 2,
   parameter int BYPASS    = 0
) (
   input  logic               clk,
   input  logic               rst,
   lvt_multiport_ram_if.slave bus
);
   localparam int AW    = BLOCKSIZE + 1;
   localparam int DEPTH = 2 << BLOCKSIZE;
   localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic {INIT, READY} state_t;

   state_t           state;
   logic [AW-1:0]    ptr;
   logic             ready_q;
   logic [LW-1:0]    lvt  [DEPTH];
   logic [DW-1:0]    bank [NW][NR][DEPTH];
   logic [NW-1:0]    wr;
   logic [NR*DW-1:0] rd_next;
   logic [NR*DW-1:0] dout_q;

   assign wr         = (state == READY) ? bus.w_en : '0;
   assign bus.ready  = ready_q;
   assign bus.r_dout = dout_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= INIT;
         ptr     <= '0;
         ready_q <= 1'b0;
         for (int a = 0; a < DEPTH; a++) lvt[a] <= '0;
      end else begin
         case (state)
            INIT: begin
               lvt[ptr] <= '0;
               ptr      <= ptr + 1'b1;
               if (ptr == AW'(DEPTH - 1)) begin
                  state   <= READY;
                  ready_q <= 1'b1;
               end
            end
            READY: begin
               // Ascending order: the highest-index colliding port lands last and wins.
               for (int k = 0; k < NW; k++)
                  if (wr[k]) lvt[bus.w_addr[k*AW +: AW]] <= LW'(k);
            end
            default: state <= INIT;
         endcase
      end
   end

   // Bank storage has no reset; the INIT sweep is what makes it X-free.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NW; k++)
         for (int j = 0; j < NR; j++)
            if (state == INIT)
               bank[k][j][ptr] <= '0;
            else if (wr[k])
               bank[k][j][bus.w_addr[k*AW +: AW]] <= bus.w_din[k*DW +: DW];
   end

   always_comb begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      rd_next = '0;
      ra      = '0;
      rd      = '0;
      for (int j = 0; j < NR; j++) begin
         ra = bus.r_addr[j*AW +: AW];
         rd = bank[lvt[ra]][j][ra];
         if (BYPASS != 0)
            for (int k = 0; k < NW; k++)
               if (wr[k] && (bus.w_addr[k*AW +: AW] == ra)) rd = bus.w_din[k*DW +: DW];
         rd_next[j*DW +: DW] = rd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                dout_q <= '0;
      else if (state == INIT)  dout_q <= '0;
      else                     dout_q <= rd_next;
   end
endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Directed bench for lvt_multiport_ram: one BYPASS=0 and one BYPASS=1 instance share stimulus.
module tb_lvt_multiport_ram;
   localparam int AW    = 11;
   localparam int DW    = 32;
   localparam int DEPTH = 2048;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   lvt_multiport_ram_if #(.AW(AW), .DW(DW), .NW(2), .NR(2)) if0 ();
   lvt_multiport_ram_if #(.AW(AW), .DW(DW), .NW(2), .NR(2)) if1 ();

   lvt_multiport_ram #(.BLOCKSIZE(10), .DW(DW), .NW(2), .NR(2), .BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .bus(if0));
   lvt_multiport_ram #(.BLOCKSIZE(10), .DW(DW), .NW(2), .NR(2), .BYPASS(1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1));

   logic [DW-1:0] gold [DEPTH];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      if0.w_en = en; if0.w_addr = {a1, a0}; if0.w_din = {d1, d0}; if0.r_addr = {r1, r0};
      if1.w_en = en; if1.w_addr = {a1, a0}; if1.w_din = {d1, d0}; if1.r_addr = {r1, r0};
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs the full clear sweep while hammering writes at addr_w; checks ready timing and zero reads.
   task automatic sweep(input string tag, input logic [AW-1:0] addr_w);
      int bad_ready = 0;
      int bad_dout  = 0;
      for (int n = 0; n < DEPTH - 1; n++) begin
         drive(2'b11, addr_w, addr_w, 32'hDEAD_0000 + n, 32'hBEEF_0000 + n,
               AW'($urandom_range(0, DEPTH - 1)), addr_w);
         step();
         if (if0.ready !== 1'b0 || if1.ready !== 1'b0) bad_ready++;
         if (if0.r_dout !== 64'd0 || if1.r_dout !== 64'd0) bad_dout++;
      end
      check({tag, "_ready_low_count"}, 64'(bad_ready), 64'd0);
      check({tag, "_dout_zero_count"}, 64'(bad_dout), 64'd0);
      step();
      check({tag, "_ready_rise"}, {62'd0, if0.ready, if1.ready}, 64'd3);
      drive(2'b00, '0, '0, '0, '0, '0, '0);
   endtask

   initial begin
      logic [DW-1:0] e0 [2];
      logic [DW-1:0] e1 [2];
      logic [1:0]    en;
      logic [AW-1:0] wa [2];
      logic [DW-1:0] wd [2];
      logic [AW-1:0] ra [2];

      drive(2'b00, '0, '0, '0, '0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", {if0.ready, if1.ready, if0.r_dout, 62'd0} >> 62, 64'd0);
      check("reset_dout1", if1.r_dout, 64'd0);
      rst = 1'b1;

      // 1: initial sweep, writes at address 0 must be ignored
      sweep("sweep1", 11'd0);
      drive(2'b00, '0, '0, '0, '0, 11'd0, 11'd1);
      step();
      check("init_write_ignored_0", if0.r_dout, 64'd0);
      check("init_write_ignored_1", if1.r_dout, 64'd0);

      // 2: simple write then read on both ports
      drive(2'b01, 11'd5, '0, 32'hAA, '0, '0, '0);
      step();
      drive(2'b00, '0, '0, '0, '0, 11'd5, 11'd5);
      step();
      check("wr5_bp0", if0.r_dout, {32'hAA, 32'hAA});
      check("wr5_bp1", if1.r_dout, {32'hAA, 32'hAA});

      // 3: collision, port 1 wins
      drive(2'b11, 11'd7, 11'd7, 32'h11, 32'h22, '0, '0);
      step();
      drive(2'b00, '0, '0, '0, '0, 11'd7, 11'd7);
      step();
      check("collide7_bp0", if0.r_dout, {32'h22, 32'h22});
      check("collide7_bp1", if1.r_dout, {32'h22, 32'h22});

      // 4: same-edge read/write, BYPASS behaviour
      drive(2'b01, 11'd9, '0, 32'h33, '0, '0, '0);
      step();
      drive(2'b01, 11'd9, '0, 32'h44, '0, 11'd9, 11'd9);
      step();
      check("rdw9_bp0_old", if0.r_dout, {32'h33, 32'h33});
      check("rdw9_bp1_new", if1.r_dout, {32'h44, 32'h44});
      drive(2'b00, '0, '0, '0, '0, 11'd9, 11'd9);
      step();
      check("rd9_after_bp0", if0.r_dout, {32'h44, 32'h44});
      check("rd9_after_bp1", if1.r_dout, {32'h44, 32'h44});

      // collision with bypass: highest index forwarded
      drive(2'b11, 11'd12, 11'd12, 32'h66, 32'h77, 11'd12, 11'd5);
      step();
      check("bypass_collide_bp0", if0.r_dout, {32'hAA, 32'h0});
      check("bypass_collide_bp1", if1.r_dout, {32'hAA, 32'h77});

      // 5: reset mid-traffic
      drive(2'b01, 11'd3, '0, 32'h55, '0, '0, '0);
      step();
      drive(2'b00, '0, '0, '0, '0, 11'd3, 11'd3);
      step();
      check("wr3_before_reset", if0.r_dout, {32'h55, 32'h55});
      rst = 1'b0;
      #1;
      check("async_reset_ready", {62'd0, if0.ready, if1.ready}, 64'd0);
      check("async_reset_dout0", if0.r_dout, 64'd0);
      check("async_reset_dout1", if1.r_dout, 64'd0);
      step();
      rst = 1'b1;
      sweep("sweep2", 11'd3);
      drive(2'b00, '0, '0, '0, '0, 11'd3, 11'd9);
      step();
      check("cleared_bp0", if0.r_dout, 64'd0);
      check("cleared_bp1", if1.r_dout, 64'd0);

      // 6: random soak on a small address window to force collisions
      for (int a = 0; a < DEPTH; a++) gold[a] = '0;
      for (int n = 0; n < 3000; n++) begin
         int errs_before = errors;
         en = 2'($urandom_range(0, 3));
         for (int k = 0; k < 2; k++) begin
            wa[k] = AW'($urandom_range(0, 15));
            wd[k] = $urandom;
            ra[k] = AW'($urandom_range(0, 15));
         end
         for (int j = 0; j < 2; j++) e0[j] = gold[ra[j]];
         for (int k = 0; k < 2; k++) if (en[k]) gold[wa[k]] = wd[k];
         for (int j = 0; j < 2; j++) e1[j] = gold[ra[j]];
         drive(en, wa[0], wa[1], wd[0], wd[1], ra[0], ra[1]);
         step();
         check("soak_bp0", if0.r_dout, {e0[1], e0[0]});
         check("soak_bp1", if1.r_dout, {e1[1], e1[0]});
         if (errors != errs_before) break;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
